// File: rtl/attack_pkg.sv
// attack_pkg: shared state encoding, move codes and default timing/damage for attack_resolver.
package attack_pkg;

    typedef enum logic [2:0] {IDLE, STARTUP, ACTIVE, RECOVERY, STUNNED} state_t;

    localparam logic [1:0] MV_NONE    = 2'd0;
    localparam logic [1:0] MV_NORMAL  = 2'd1;
    localparam logic [1:0] MV_SPECIAL = 2'd2;
    localparam logic [1:0] MV_SUPER   = 2'd3;

    localparam int STARTUP_N_DEF = 2;
    localparam int STARTUP_S_DEF = 3;
    localparam int STARTUP_U_DEF = 5;
    localparam int RECOVER_N_DEF = 2;
    localparam int RECOVER_S_DEF = 4;
    localparam int RECOVER_U_DEF = 6;
    localparam int STUN_N_DEF    = 4;
    localparam int STUN_S_DEF    = 6;
    localparam int STUN_U_DEF    = 8;
    localparam int DMG_N_DEF     = 4;
    localparam int DMG_S_DEF     = 8;
    localparam int DMG_U_DEF     = 16;

    localparam int CH_DMG_BONUS  = 4;
    localparam int CH_STUN_BONUS = 2;

    function automatic logic [4:0] pick(input logic [1:0] m, input int n, input int s, input int u);
        return m == MV_SUPER ? 5'(u) : m == MV_SPECIAL ? 5'(s) : 5'(n);
    endfunction

endpackage

// File: rtl/attack_fsm.sv
// attack_fsm: per-player attack lifecycle (startup/active/recovery/stun) with latched move.
// ATTACK_RESOLVER_COUNTER_HIT_EN: extends stun when struck during STARTUP.
module attack_fsm
    import attack_pkg::*;
#(
    parameter int STARTUP_N = STARTUP_N_DEF,
    parameter int STARTUP_S = STARTUP_S_DEF,
    parameter int STARTUP_U = STARTUP_U_DEF,
    parameter int RECOVER_N = RECOVER_N_DEF,
    parameter int RECOVER_S = RECOVER_S_DEF,
    parameter int RECOVER_U = RECOVER_U_DEF,
    parameter int STUN_N    = STUN_N_DEF,
    parameter int STUN_S    = STUN_S_DEF,
    parameter int STUN_U    = STUN_U_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] combo,
    input  logic       in_play,
    input  logic       got_hit,
    input  logic       got_blocked,
    input  logic [1:0] hit_move,
    output logic [2:0] state,
    output logic [1:0] move
);

    state_t     st, st_n;
    logic [3:0] cnt, cnt_n;
    logic [1:0] mv_n;
    logic [4:0] stun_len, stun_ch;

    assign state   = st;
    assign stun_ch = pick(hit_move, STUN_N, STUN_S, STUN_U) + 5'(CH_STUN_BONUS);
`ifdef ATTACK_RESOLVER_COUNTER_HIT_EN
    assign stun_len = st == STARTUP ? (stun_ch > 5'd15 ? 5'd15 : stun_ch)
                                    : pick(hit_move, STUN_N, STUN_S, STUN_U);
`else
    assign stun_len = pick(hit_move, STUN_N, STUN_S, STUN_U);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            st   <= IDLE;
            cnt  <= 4'd0;
            move <= MV_NONE;
        end else begin
            st   <= st_n;
            cnt  <= cnt_n;
            move <= mv_n;
        end
    end

    always_comb begin
        st_n  = st;
        cnt_n = cnt;
        mv_n  = move;
        if (got_hit) begin
            // stun overrides everything, reloading rather than extending
            st_n  = STUNNED;
            cnt_n = 4'(stun_len - 5'd1);
            mv_n  = MV_NONE;
        end else begin
            case (st)
                IDLE: if (combo != MV_NONE && in_play && !got_blocked) begin
                    st_n  = STARTUP;
                    mv_n  = combo;
                    cnt_n = 4'(pick(combo, STARTUP_N, STARTUP_S, STARTUP_U) - 5'd1);
                end
                STARTUP: begin
                    st_n  = cnt == 4'd0 ? ACTIVE : STARTUP;
                    cnt_n = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
                end
                ACTIVE: begin
                    st_n  = RECOVERY;
                    cnt_n = 4'(pick(move, RECOVER_N, RECOVER_S, RECOVER_U) - 5'd1);
                end
                RECOVERY, STUNNED: begin
                    st_n  = cnt == 4'd0 ? IDLE : st;
                    cnt_n = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
                    mv_n  = cnt == 4'd0 ? MV_NONE : move;
                end
                default: st_n = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/attack_resolver.sv
// attack_resolver: cross-player hit/block resolution and registered damage pulses.
// ATTACK_RESOLVER_COUNTER_HIT_EN: bonus damage/stun for hits landing during STARTUP.
module attack_resolver
    import attack_pkg::*;
#(
    parameter int STARTUP_N = STARTUP_N_DEF,
    parameter int STARTUP_S = STARTUP_S_DEF,
    parameter int STARTUP_U = STARTUP_U_DEF,
    parameter int RECOVER_N = RECOVER_N_DEF,
    parameter int RECOVER_S = RECOVER_S_DEF,
    parameter int RECOVER_U = RECOVER_U_DEF,
    parameter int STUN_N    = STUN_N_DEF,
    parameter int STUN_S    = STUN_S_DEF,
    parameter int STUN_U    = STUN_U_DEF,
    parameter int DMG_N     = DMG_N_DEF,
    parameter int DMG_S     = DMG_S_DEF,
    parameter int DMG_U     = DMG_U_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_play,
    input  logic [1:0] combo_p1,
    input  logic [1:0] combo_p2,
    input  logic       blocking_p1,
    input  logic       blocking_p2,
    input  logic       hit_range,
    output logic       attacking_p1,
    output logic       attacking_p2,
    output logic       stunned_p1,
    output logic       stunned_p2,
    output logic       hit_p1,
    output logic       hit_p2,
    output logic [4:0] dmg_p1,
    output logic [4:0] dmg_p2
);

    logic [2:0] st1, st2;
    logic [1:0] mv1, mv2;
    logic       strike1, strike2, blk1, blk2, ch1, ch2;

    function automatic logic [4:0] dmg_calc(input logic [1:0] m, input logic blk, input logic ch);
        logic [4:0] base;
        logic [5:0] sum;
        base = pick(m, DMG_N, DMG_S, DMG_U);
        sum  = {1'b0, base} + 6'(CH_DMG_BONUS);
        return blk ? base >> 1 : ch ? (sum > 6'd31 ? 5'd31 : sum[4:0]) : base;
    endfunction

    // strikeX: player X is being struck this cycle
    assign strike1 = st2 == ACTIVE && hit_range && in_play;
    assign strike2 = st1 == ACTIVE && hit_range && in_play;
    assign blk1    = blocking_p1 && (st1 == IDLE || st1 == STUNNED);
    assign blk2    = blocking_p2 && (st2 == IDLE || st2 == STUNNED);
`ifdef ATTACK_RESOLVER_COUNTER_HIT_EN
    assign ch1 = st1 == STARTUP;
    assign ch2 = st2 == STARTUP;
`else
    assign ch1 = 1'b0;
    assign ch2 = 1'b0;
`endif

    assign attacking_p1 = st1 == STARTUP || st1 == ACTIVE || st1 == RECOVERY;
    assign attacking_p2 = st2 == STARTUP || st2 == ACTIVE || st2 == RECOVERY;
    assign stunned_p1   = st1 == STUNNED;
    assign stunned_p2   = st2 == STUNNED;

    attack_fsm #(
        .STARTUP_N(STARTUP_N), .STARTUP_S(STARTUP_S), .STARTUP_U(STARTUP_U),
        .RECOVER_N(RECOVER_N), .RECOVER_S(RECOVER_S), .RECOVER_U(RECOVER_U),
        .STUN_N(STUN_N), .STUN_S(STUN_S), .STUN_U(STUN_U)
    ) u_p1 (
        .clk(clk), .reset(reset), .combo(combo_p1), .in_play(in_play),
        .got_hit(strike1 && !blk1), .got_blocked(strike1 && blk1), .hit_move(mv2),
        .state(st1), .move(mv1)
    );

    attack_fsm #(
        .STARTUP_N(STARTUP_N), .STARTUP_S(STARTUP_S), .STARTUP_U(STARTUP_U),
        .RECOVER_N(RECOVER_N), .RECOVER_S(RECOVER_S), .RECOVER_U(RECOVER_U),
        .STUN_N(STUN_N), .STUN_S(STUN_S), .STUN_U(STUN_U)
    ) u_p2 (
        .clk(clk), .reset(reset), .combo(combo_p2), .in_play(in_play),
        .got_hit(strike2 && !blk2), .got_blocked(strike2 && blk2), .hit_move(mv1),
        .state(st2), .move(mv2)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_p1 <= 1'b0;
            hit_p2 <= 1'b0;
            dmg_p1 <= 5'd0;
            dmg_p2 <= 5'd0;
        end else begin
            hit_p1 <= strike1;
            hit_p2 <= strike2;
            dmg_p1 <= strike1 ? dmg_calc(mv2, blk1, ch1) : 5'd0;
            dmg_p2 <= strike2 ? dmg_calc(mv1, blk2, ch2) : 5'd0;
        end
    end

endmodule

// File: tb/tb_attack_resolver.sv
// tb_attack_resolver: directed scenarios with a hit-event scoreboard checked by an independent monitor.
module tb_attack_resolver;

    logic       clk = 1'b0;
    logic       reset, in_play, blocking_p1, blocking_p2, hit_range;
    logic [1:0] combo_p1, combo_p2;
    logic       attacking_p1, attacking_p2, stunned_p1, stunned_p2, hit_p1, hit_p2;
    logic [4:0] dmg_p1, dmg_p2;

    typedef struct {int cyc; bit p; int dmg;} ev_t;
    ev_t sb[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;

`ifdef ATTACK_RESOLVER_COUNTER_HIT_EN
    localparam int CH_DMG = 8, CH_STUN = 6;
`else
    localparam int CH_DMG = 4, CH_STUN = 4;
`endif

    attack_resolver dut (
        .clk(clk), .reset(reset), .in_play(in_play),
        .combo_p1(combo_p1), .combo_p2(combo_p2),
        .blocking_p1(blocking_p1), .blocking_p2(blocking_p2), .hit_range(hit_range),
        .attacking_p1(attacking_p1), .attacking_p2(attacking_p2),
        .stunned_p1(stunned_p1), .stunned_p2(stunned_p2),
        .hit_p1(hit_p1), .hit_p2(hit_p2), .dmg_p1(dmg_p1), .dmg_p2(dmg_p2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", n, cyc, act, exp);
        end
    endtask

    task automatic pop_chk(input bit p, input int d);
        ev_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_hit at cycle %0d: p%0d dmg %0d, expected no hit", cyc, p + 1, d);
        end else begin
            e = sb.pop_front();
            chk("hit_cycle", cyc, e.cyc);
            chk("hit_player", p + 1, e.p + 1);
            chk("hit_dmg", d, e.dmg);
        end
    endtask

    always @(negedge clk) begin
        if (hit_p1) pop_chk(1'b0, dmg_p1);
        if (hit_p2) pop_chk(1'b1, dmg_p2);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int outs();
        return {attacking_p1, attacking_p2, stunned_p1, stunned_p2, hit_p1, hit_p2, dmg_p1, dmg_p2};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int c;
        reset = 1'b0; in_play = 1'b1; hit_range = 1'b0;
        combo_p1 = 2'd0; combo_p2 = 2'd0; blocking_p1 = 1'b0; blocking_p2 = 1'b0;
        step(2);
        chk("reset_outputs", outs(), 0);
        reset = 1'b1;
        step(1);

        // reset in the middle of a P1 super
        hit_range = 1'b1; combo_p1 = 2'd3;
        step(1);
        combo_p1 = 2'd0;
        chk("super_started", attacking_p1, 1);
        step(2);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("reset_mid_attack", outs(), 0);
        end
        reset = 1'b1;
        step(1);
        chk("idle_after_reset", attacking_p1, 0);
        step(8);

        // normal hit on idle, non-blocking P2
        c = cyc; combo_p1 = 2'd1;
        sb.push_back('{c + 4, 1'b1, 4});
        step(1);
        combo_p1 = 2'd0;
        for (int i = 1; i <= 9; i++) begin
            chk("normal_attacking_p1", attacking_p1, int'(i <= 5));
            chk("normal_stunned_p2", stunned_p2, int'(i >= 4 && i <= 7));
            step(1);
        end

        // blocked special
        c = cyc; combo_p1 = 2'd2; blocking_p2 = 1'b1;
        sb.push_back('{c + 5, 1'b1, 4});
        step(1);
        combo_p1 = 2'd0;
        for (int i = 1; i <= 9; i++) begin
            chk("block_attacking_p1", attacking_p1, int'(i <= 8));
            chk("block_stunned_p2", stunned_p2, 0);
            step(1);
        end
        blocking_p2 = 1'b0;
        step(2);

        // trade: both normals active together
        c = cyc; combo_p1 = 2'd1; combo_p2 = 2'd1;
        sb.push_back('{c + 4, 1'b0, 4});
        sb.push_back('{c + 4, 1'b1, 4});
        step(1);
        combo_p1 = 2'd0; combo_p2 = 2'd0;
        for (int i = 1; i <= 8; i++) begin
            chk("trade_attacking_p1", attacking_p1, int'(i <= 3));
            chk("trade_attacking_p2", attacking_p2, int'(i <= 3));
            chk("trade_stunned_p1", stunned_p1, int'(i >= 4 && i <= 7));
            chk("trade_stunned_p2", stunned_p2, int'(i >= 4 && i <= 7));
            step(1);
        end
        step(2);

        // out of play during P1's ACTIVE cycle
        combo_p1 = 2'd1;
        step(1);
        combo_p1 = 2'd0;
        step(2);
        in_play = 1'b0;
        step(1);
        in_play = 1'b1;
        chk("oop_no_hit", hit_p2, 0);
        chk("oop_recovery_4", attacking_p1, 1);
        step(1);
        chk("oop_recovery_5", attacking_p1, 1);
        step(1);
        chk("oop_done", attacking_p1, 0);
        step(3);

        // P2 struck during super STARTUP
        c = cyc; combo_p1 = 2'd1; combo_p2 = 2'd3;
        sb.push_back('{c + 4, 1'b1, CH_DMG});
        step(1);
        combo_p1 = 2'd0; combo_p2 = 2'd0;
        for (int i = 1; i <= 12; i++) begin
            chk("ch_attacking_p2", attacking_p2, int'(i <= 3));
            chk("ch_stunned_p2", stunned_p2, int'(i >= 4 && i < 4 + CH_STUN));
            step(1);
        end

        step(4);
        chk("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/attack_resolver.md
# attack_resolver

Resolves each fighter's attack lifecycle and converts landed attacks into damage events, sitting between the two `playerMovementHandler` instances and `HealthManagement` in the 20 Hz game-tick domain. It consumes the combo codes and the shared hit-range flag. It produces the `isPerformingAttackAnimation` and `isStunned` feedback that the movement handlers need. It also produces registered per-player damage pulses that the health stage accumulates.

## Interface
Parameters:
- `STARTUP_N/S/U`, default 2/3/5: startup ticks for normal/special/super.
- `RECOVER_N/S/U`, default 2/4/6: recovery ticks.
- `STUN_N/S/U`, default 4/6/8: stun ticks inflicted on the defender.
- `DMG_N/S/U`, default 4/8/16: damage per move, 5-bit values.

Ports:
- `clk`  in  1: game tick (CLK_20Hz); one cycle equals one tick.
- `reset`  in  1: synchronous, active-low.
- `in_play`  in  1: high while the round is live (winner undecided).
- `combo_p1`, `combo_p2`  in  2 each: 0 = none, 1 = normal, 2 = special, 3 = super.
- `blocking_p1`, `blocking_p2`  in  1 each: defender block request.
- `hit_range`  in  1: fighters are within strike distance (symmetric).
- `attacking_p1`, `attacking_p2`  out  1 each: high in STARTUP, ACTIVE and RECOVERY.
- `stunned_p1`, `stunned_p2`  out  1 each: high in STUNNED.
- `hit_p1`, `hit_p2`  out  1 each: one-cycle pulse; that player was struck.
- `dmg_p1`, `dmg_p2`  out  5 each: damage for the pulse; 0 when the pulse is low.

## Operation
Each player runs a per-player FSM with states IDLE, STARTUP, ACTIVE, RECOVERY, STUNNED.

- **IDLE → STARTUP**: when `combo_pX != 0` and `in_play` is high. The move code is latched, and the counter is loaded with startup−1. Combo changes after the latch are ignored until the FSM returns to IDLE.
- **STARTUP → ACTIVE**: when the counter reaches 0. ACTIVE always lasts exactly 1 cycle.
- **ACTIVE → RECOVERY**: on the next edge, with the counter loaded with recover−1.
- **RECOVERY → IDLE**: when the counter reaches 0.
- **Hit rule**: a hit lands when the attacker is in ACTIVE, `hit_range` is high and `in_play` is high, all sampled in that cycle.
- **Unblocked hit**:
  - the defender receives the latched move's damage;
  - the defender enters STUNNED with its counter loaded with stun−1.
  - An in-progress attack by the defender is aborted.
- **Blocked hit**: the defender has `blocking_pX` high and is in IDLE or STUNNED.
  - Damage is halved (`>>1`), giving 2, 4 or 8.
  - The defender's state is unchanged.
  - A defender in STARTUP, ACTIVE or RECOVERY cannot block.
- **STUNNED → IDLE**: when the counter reaches 0. Combo input is ignored while stunned.
- **Hit during STUNNED**: the stun counter is reloaded with the new value, not added to the remaining count.
- **Simultaneous ACTIVE (trade)**: both hits land. Each player's STUNNED transition overrides its own ACTIVE → RECOVERY transition. Stun has priority over every other transition.
- **`in_play` low**: no new attacks start and no hits register. In-flight FSMs run to IDLE normally.

## Timing
- **Reset**: all FSMs go to IDLE, counters clear, and every output is 0 on the first edge with `reset` low.
- **Reset mid-attack or mid-stun**: the FSM returns to IDLE immediately and any pending hit is discarded.
- **Combo latency**: `combo_pX` asserted before edge k puts the FSM in STARTUP after edge k. `attacking_pX` is high from cycle k+1.
- **Hit latency**: a hit is evaluated in the ACTIVE cycle. `hit_pY`/`dmg_pY` are registered and high for exactly the cycle after that edge. `stunned_pY` rises in the same cycle.
- **Total attack length**: startup + 1 + recover ticks; a normal attack lasts 5 ticks.
- **Outputs**: all outputs are registered, with no combinational input-to-output path.
- **Counters**: 4 bits wide, and values never wrap. Parameters must be ≥1 and ≤15.

## Configuration
- **`ATTACK_RESOLVER_COUNTER_HIT_EN` defined**: an unblocked hit on a defender in STARTUP is a counter hit. Damage becomes move damage + 4, saturated at 31. Stun becomes stun + 2, saturated at 15.
- **Macro undefined**: a hit on a defender in STARTUP is treated as a normal unblocked hit.

## Structure
- **Package `attack_pkg`**:
  - state enum;
  - move-code constants (NONE/NORMAL/SPECIAL/SUPER);
  - default duration and damage constants;
  - counter-hit bonus constants.
- **Sub-module `attack_fsm`**: one per player, instantiated twice. Each instance holds the state, counter and latched move.
  - Inputs: combo, `in_play`, `got_hit`, `got_blocked`, `hit_move`.
  - Outputs: `state`, `move`.
- **Top level**: the top of `attack_resolver` performs the cross-player hit/block resolution and registers the damage outputs.

## Test plan
- **Reset**: hold `reset` low 3 cycles during a P1 super → all outputs 0, and P1 is IDLE on release.
- **Normal hit**: P1 `combo` = 1, `hit_range` = 1, P2 idle not blocking → `hit_p2` pulses in cycle 4 with `dmg_p2` = 4. `stunned_p2` is high for 4 cycles. `attacking_p1` is high cycles 1–5.
- **Blocked special**: P1 special with P2 blocking in IDLE → `dmg_p2` = 4 and `stunned_p2` stays 0.
- **Trade**: both players start a normal on the same cycle with `hit_range` = 1 → both pulse with damage 4 and both are stunned. Neither enters RECOVERY.
- **Out of play**: `in_play` = 0 during P1's ACTIVE cycle → no hit pulse, and P1 still completes RECOVERY.
- **Counter hit (macro on)**: P2 in STARTUP of a super when P1's normal becomes ACTIVE → `dmg_p2` = 8 and stun lasts 6 cycles. With the macro off → `dmg_p2` = 4 and stun lasts 4 cycles.
